// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and
// the clocks-per-bit helper. Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD     = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Integer clock periods per serial bit (truncating division).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_read_if.sv
// Parallel output bus of the UART receiver.
// Handshake: valid, frame_err and parity_err are single-cycle strobes with
// no ready/backpressure; the consumer must capture data in the valid cycle
// or at any time before the next good frame replaces it. At most one of the
// three strobes is high in any cycle. state is a debug view of the FSM.
interface uart_read_if;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic [2:0] state;

  modport master (output data, valid, busy, frame_err, parity_err, state);
  modport slave  (input  data, valid, busy, frame_err, parity_err, state);
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input. Resets to 1 so
// an idle line does not look like activity while reset is released.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_read.sv
// UART receiver, 8N1, LSB first. Samples rx_pin in the clock_50mhz domain,
// checks the start bit at its centre, samples data/stop bits at bit centres
// and emits one-cycle valid / frame_err / parity_err strobes.
// Optional build macro UART_READ_PARITY_EN adds an even-parity bit after the
// data bits; without it parity_err is tied low.
module uart_read
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD     = DEFAULT_BAUD
) (
  input  logic       clock_50mhz,
  input  logic       rst_n,
  input  logic       rx_pin,
  uart_read_if.master rx_bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [8:0]  BIT_LAST     = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0]  HALF_LAST    = 9'(HALF_BIT - 1);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] START  = ST_START;
  localparam logic [2:0] DATA   = ST_DATA;
`ifdef UART_READ_PARITY_EN
  localparam logic [2:0] PARITY = ST_PARITY;
`endif
  localparam logic [2:0] STOP   = ST_STOP;
  localparam logic [2:0] BREAK  = ST_BREAK;

  logic       rx_s;
  logic       rx_prev;
  logic [1:0] settle;
  logic       fall;
  logic [2:0] state;
  logic [8:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [7:0] data_q;
  logic       valid_q;
  logic       ferr_q;
`ifdef UART_READ_PARITY_EN
  logic       par_bit;
  logic       perr_q;
  logic       par_bad;
  assign par_bad = ^{shift, par_bit};
`endif

  uart_sync u_sync (
    .clk   (clock_50mhz),
    .rst_n (rst_n),
    .d     (rx_pin),
    .q     (rx_s)
  );

  // Edges are only trusted once both synchronizer stages and rx_prev hold
  // real line samples, so a line already low at reset release is no start.
  assign fall = (settle == 2'd3) && rx_prev && !rx_s;

  // Track previous line level and post-reset settling.
  always_ff @(posedge clock_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev <= 1'b1;
      settle  <= 2'd0;
    end else begin
      rx_prev <= rx_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  // Frame FSM: bit-centre sampling, shift register and output strobes.
  always_ff @(posedge clock_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 9'd0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_READ_PARITY_EN
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_READ_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= 9'd0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= 9'd0;
            bit_idx <= 3'd0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= 9'd0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_READ_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
`ifdef UART_READ_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= 9'd0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= 9'd0;
            if (!rx_s) begin
              ferr_q <= 1'b1;
              state  <= BREAK;
`ifdef UART_READ_PARITY_EN
            end else if (par_bad) begin
              perr_q <= 1'b1;
              state  <= IDLE;
`endif
            end else begin
              data_q  <= shift;
              valid_q <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_bus.data      = data_q;
  assign rx_bus.valid     = valid_q;
  assign rx_bus.busy      = (state != IDLE);
  assign rx_bus.frame_err = ferr_q;
  assign rx_bus.state     = state;
`ifdef UART_READ_PARITY_EN
  assign rx_bus.parity_err = perr_q;
`else
  assign rx_bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_read.sv
// Bench for uart_read: directed frames plus random bytes, with a frame-level
// reference model producing the expected strobe stream and output data.
module tb_uart_read;

  localparam int CPB = 50_000_000 / 115_200;
  localparam int HALF = CPB / 2;
`ifdef UART_READ_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + HALF + (PAR_EN ? 10 : 9) * CPB;
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_FERR  = 2'd2;
  localparam logic [1:0] K_PERR  = 2'd3;

  // clock / reset
  logic clock_50mhz = 1'b0;
  logic rst_n = 1'b0;
  logic rx_pin = 1'b1;
  always #10 clock_50mhz = ~clock_50mhz;

  uart_read_if bus ();
  uart_read dut (
    .clock_50mhz (clock_50mhz),
    .rst_n       (rst_n),
    .rx_pin      (rx_pin),
    .rx_bus      (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];
  int start_q[$];
  logic [7:0] mdl_data = 8'h00;

  always @(posedge clock_50mhz) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  logic prev_pulse = 1'b0;
  int n_pulse;
  int lat;
  logic [1:0] kind_obs;
  logic [9:0] e_item;
  int e_start;
  always @(negedge clock_50mhz) begin
    n_pulse = int'(bus.valid) + int'(bus.frame_err) + int'(bus.parity_err);
    if (n_pulse > 0) begin
      chk("pulse_exclusive", n_pulse, 1);
      chk("pulse_width", {31'd0, prev_pulse}, 0);
      kind_obs = bus.valid ? K_VALID : (bus.frame_err ? K_FERR : K_PERR);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, kind_obs}, 0);
      end else begin
        e_item  = exp_q.pop_front();
        e_start = start_q.pop_front();
        chk("pulse_kind", {30'd0, kind_obs}, {30'd0, e_item[9:8]});
        if (kind_obs == K_VALID) begin
          chk("rx_data", {24'd0, bus.data}, {24'd0, e_item[7:0]});
          mdl_data = e_item[7:0];
          lat = cyc - e_start;
          chk($sformatf("latency_%0d_vs_%0d", lat, LAT),
              {31'd0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 1);
        end
      end
    end
    prev_pulse = (n_pulse > 0);
  end

  // driver tasks
  task automatic drive_bit(input logic v);
    rx_pin = v;
    repeat (CPB) @(negedge clock_50mhz);
  endtask

  // Frame-level model: stop low -> frame error; bad even parity (when built
  // in) -> parity error; otherwise the byte is delivered.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input logic par_b, input int hold_low);
    logic [1:0] kind;
    if (!stop_b) kind = K_FERR;
    else if (PAR_EN && ((^b) ^ par_b)) kind = K_PERR;
    else kind = K_VALID;
    exp_q.push_back({kind, b});
    start_q.push_back(cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par_b);
    drive_bit(stop_b);
    if (hold_low > 0) begin
      rx_pin = 1'b0;
      repeat (hold_low) @(negedge clock_50mhz);
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, ^b, 0);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2 * LAT) begin
      @(negedge clock_50mhz);
      t++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic bad;
    rx_pin = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clock_50mhz);
    chk("reset_data", {24'd0, bus.data}, 0);
    chk("reset_valid", {31'd0, bus.valid}, 0);
    chk("reset_busy", {31'd0, bus.busy}, 0);
    chk("reset_frame_err", {31'd0, bus.frame_err}, 0);
    chk("reset_parity_err", {31'd0, bus.parity_err}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clock_50mhz);

    // two basic frames with idle between
    send_good(8'h55);
    chk("busy_between", {31'd0, bus.busy}, 0);
    repeat (20) @(negedge clock_50mhz);
    send_good(8'hA3);
    drain("drain_basic");
    chk("data_after_basic", {24'd0, bus.data}, {24'd0, mdl_data});

    // short low glitch: false start rejected at the half-bit check
    rx_pin = 1'b0;
    repeat (50) @(negedge clock_50mhz);
    chk("glitch_busy_high", {31'd0, bus.busy}, 1);
    repeat (50) @(negedge clock_50mhz);
    rx_pin = 1'b1;
    repeat (130) @(negedge clock_50mhz);
    chk("glitch_busy_low", {31'd0, bus.busy}, 0);
    repeat (500) @(negedge clock_50mhz);

    // framing error followed by a 2000-clock break
    send_frame(8'h3C, 1'b0, ^8'h3C, 2000);
    chk("break_busy", {31'd0, bus.busy}, 1);
    rx_pin = 1'b1;
    drain("drain_ferr");
    repeat (10) @(negedge clock_50mhz);
    chk("break_exit_busy", {31'd0, bus.busy}, 0);
    chk("data_hold_after_ferr", {24'd0, bus.data}, 8'hA3);
    repeat (CPB) @(negedge clock_50mhz);
    send_good(8'h81);
    drain("drain_81");

    // back-to-back frames, zero idle gap
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h7E);
    drain("drain_b2b");

    // reset in the middle of bit 4 (line low), released with line still low
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_pin = 1'b0;
    repeat (200) @(negedge clock_50mhz);
    rst_n = 1'b0;
    repeat (2) @(negedge clock_50mhz);
    chk("midreset_data", {24'd0, bus.data}, 0);
    chk("midreset_busy", {31'd0, bus.busy}, 0);
    mdl_data = 8'h00;
    repeat (8) @(negedge clock_50mhz);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clock_50mhz);
    chk("low_line_no_start", {31'd0, bus.busy}, 0);
    rx_pin = 1'b1;
    repeat (CPB) @(negedge clock_50mhz);
    send_good(8'h99);
    drain("drain_99");

    // parity cases (delivered as plain frames when parity is not built in)
    send_frame(8'h07, 1'b1, 1'b1, 0);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    drain("drain_parity");
    chk("data_after_parity", {24'd0, bus.data}, {24'd0, mdl_data});

    // random bytes with random gaps
    for (int k = 0; k < 4; k++) begin
      rb  = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      send_frame(rb, 1'b1, (^rb) ^ bad, 0);
      repeat ($urandom_range(0, 40)) @(negedge clock_50mhz);
    end
    drain("drain_random");
    chk("final_busy", {31'd0, bus.busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
